// File: rtl/mix_columns_seq.sv
// -----------------------------------------------------------------------------
// mix_columns_seq
//   Iterative AES MixColumns engine. One 32-bit column datapath, built from
//   four GF(2^8) multiply-by-3 units, is time-shared across the NCOL columns
//   of the 128-bit state, one column per clock. A skip flag sampled at
//   acceptance bypasses mixing for the final AES round.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous, active-low reset
//   in_valid   in   state_in / skip valid
//   in_ready   out  block can accept a new state (IDLE only)
//   skip       in   1 = pass state through unmixed
//   state_in   in   column c = bits [127-32c -: 32], byte 0 is the MS byte
//   out_valid  out  state_out holds a complete result
//   out_ready  in   consumer accepts state_out
//   state_out  out  mixed or bypassed state, same ordering as state_in
//   busy       out  high in every state except IDLE
// -----------------------------------------------------------------------------

// GF(2^8) multiply-by-3 unit (AES polynomial x^8+x^4+x^3+x+1).
// Ports: i_byte in 8, o_byte out 8 = 3*i_byte.
module mix_columns_m3 (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_x2;

  assign w_x2   = {i_byte[6:0], 1'b0} ^ (i_byte[7] ? 8'h1b : 8'h00);
  assign o_byte = w_x2 ^ i_byte;

endmodule

module mix_columns_seq #(
  parameter int unsigned NCOL       = 4,
  parameter int unsigned BYPASS_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  skip,
  input  logic [32*NCOL-1:0]    state_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NCOL-1:0]    state_out,
  output logic                  busy
);

  localparam int unsigned SW       = 32 * NCOL;
  localparam int unsigned CW       = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(NCOL - 1);
  localparam logic [1:0]    BYP_LAST = 2'(BYPASS_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MIX,
    S_BYP,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [SW-1:0]   r_work;
  logic [SW-1:0]   r_result;
  logic [CW-1:0]   r_col;
  logic [1:0]      r_byp_cnt;
  logic            w_accept;
  logic [31:0]     w_col;
  logic [7:0]      w_a  [4];
  logic [7:0]      w_m3 [4];
  logic [7:0]      w_x2 [4];
  logic [31:0]     w_mix;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_n = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_state_n = skip ? S_BYP : S_MIX;
        end
      end
      S_MIX: begin
        if (r_col == COL_LAST) begin
          w_state_n = S_DONE;
        end
      end
      S_BYP: begin
        if (r_byp_cnt == BYP_LAST) begin
          w_state_n = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_accept = in_valid && (r_state == S_IDLE);

  // ---------------------------------------------------------------------------
  // Column select from the work register
  // ---------------------------------------------------------------------------
  always_comb begin
    w_col = '0;
    for (int unsigned c = 0; c < NCOL; c++) begin
      if (r_col == CW'(c)) begin
        w_col = r_work[SW-1-32*c -: 32];
      end
    end
  end

  assign w_a[0] = w_col[31:24];
  assign w_a[1] = w_col[23:16];
  assign w_a[2] = w_col[15:8];
  assign w_a[3] = w_col[7:0];

  // One x3 unit per input byte; x2 is recovered as 3a ^ a.
  for (genvar g = 0; g < 4; g++) begin : g_m3
    mix_columns_m3 u_m3 (
      .i_byte (w_a[g]),
      .o_byte (w_m3[g])
    );
    assign w_x2[g] = w_m3[g] ^ w_a[g];
  end

  assign w_mix[31:24] = w_x2[0] ^ w_m3[1] ^ w_a[2]  ^ w_a[3];
  assign w_mix[23:16] = w_a[0]  ^ w_x2[1] ^ w_m3[2] ^ w_a[3];
  assign w_mix[15:8]  = w_a[0]  ^ w_a[1]  ^ w_x2[2] ^ w_m3[3];
  assign w_mix[7:0]   = w_m3[0] ^ w_a[1]  ^ w_a[2]  ^ w_x2[3];

  // ---------------------------------------------------------------------------
  // Datapath registers. The mix/bypass mode lives in the FSM state itself,
  // so no separate mode register is kept.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work    <= '0;
      r_result  <= '0;
      r_col     <= '0;
      r_byp_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_work <= state_in;
      end
      unique case (r_state)
        S_MIX: begin
          for (int unsigned c = 0; c < NCOL; c++) begin
            if (r_col == CW'(c)) begin
              r_result[SW-1-32*c -: 32] <= w_mix;
            end
          end
          r_col <= (r_col == COL_LAST) ? '0 : r_col + CW'(1);
        end
        S_BYP: begin
          r_result  <= r_work;
          r_byp_cnt <= (r_byp_cnt == BYP_LAST) ? '0 : r_byp_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign state_out = r_result;

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         skip;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  mix_columns_seq #(.NCOL(4), .BYPASS_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .skip      (skip),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    logic [127:0] r;
    coef = '{8'd2, 8'd3, 8'd1, 8'd1};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(coef[(k - row + 4) % 4], a[k]);
        r[127 - 32*c - 8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one state, wait for out_valid, check latency and data; if
  // out_ready is high, also check the return to IDLE.
  task automatic run(input string tag, input logic [127:0] s, input logic sk,
                     input logic [127:0] exp, input int lat);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin tick(); k++; end
    in_valid = 1'b1;
    state_in = s;
    skip     = sk;
    tick();
    in_valid = 1'b0;
    state_in = rnd128();
    skip     = 1'($urandom);
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check({tag, "_lat"}, 128'(k), 128'(lat));
    check({tag, "_data"}, state_out, exp);
    if (out_ready) begin
      tick();
      check({tag, "_idle"}, {125'd0, in_ready, out_valid, busy}, 128'b100);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] s;
    logic [127:0] sb;
    logic [127:0] q_in [3];
    int           acc_cyc [$];
    int           idx;
    int           got;
    int           cyc;
    int           k;
    logic         rdy;
    logic         vld;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    skip      = 1'b0;
    state_in  = '0;
    out_ready = 1'b1;
    #12;
    check("reset_ctl", {125'd0, in_ready, out_valid, busy}, 128'b100);
    check("reset_out", state_out, 128'd0);
    rst_n = 1'b1;

    // FIPS-197 vectors
    run("fips_cols", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
        128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4);
    run("fips_rnd1", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
        128'h046681e5_e0cb199a_48f8d37a_2806264c, 4);

    // bypass
    run("byp", 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b1,
        128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1);

    // random mix and bypass
    for (int i = 0; i < 4; i++) begin
      s = rnd128();
      run("rnd_mix", s, 1'b0, ref_mix(s), 4);
    end
    for (int i = 0; i < 2; i++) begin
      s = rnd128();
      run("rnd_byp", s, 1'b1, s, 1);
    end

    // backpressure
    out_ready = 1'b0;
    s = rnd128();
    in_valid = 1'b1;
    state_in = s;
    skip     = 1'b0;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check("bp_lat", 128'(k), 128'd4);
    check("bp_data", state_out, ref_mix(s));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      state_in = rnd128();
      skip     = 1'($urandom);
      tick();
      check("bp_hold_data", state_out, ref_mix(s));
      check("bp_hold_ctl", {126'd0, out_valid, in_ready}, 128'b10);
    end
    sb = rnd128();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = sb;
    skip      = 1'b0;
    tick();
    check("bp_release", {125'd0, out_valid, in_ready, busy}, 128'b010);
    tick();
    check("bp_next_acc", {126'd0, in_ready, busy}, 128'b01);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check("bp_next_lat", 128'(k), 128'd4);
    check("bp_next_data", state_out, ref_mix(sb));
    tick();

    // reset during MIX after two column writes
    in_valid = 1'b1;
    state_in = rnd128();
    skip     = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", {125'd0, in_ready, out_valid, busy}, 128'b100);
    check("rst_mid_out", state_out, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("rst_ones", {4{32'h01010101}}, 1'b0, {4{32'h01010101}}, 4);

    // back-to-back
    for (int i = 0; i < 3; i++) q_in[i] = rnd128();
    idx       = 0;
    got       = 0;
    cyc       = 0;
    out_ready = 1'b1;
    skip      = 1'b0;
    in_valid  = 1'b1;
    state_in  = q_in[0];
    while (got < 3 && cyc < 80) begin
      rdy = in_ready;
      vld = in_valid;
      tick();
      cyc++;
      if (rdy && vld) begin
        acc_cyc.push_back(cyc);
        idx++;
        if (idx < 3) state_in = q_in[idx];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        check("b2b_data", state_out, ref_mix(q_in[got]));
        got++;
      end
    end
    check("b2b_count", 128'(got), 128'd3);
    check("b2b_nacc", 128'(acc_cyc.size()), 128'd3);
    if (acc_cyc.size() == 3) begin
      check("b2b_gap1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
      check("b2b_gap2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd6);
    end
    tick();
    check("b2b_idle", {125'd0, in_ready, out_valid, busy}, 128'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
